// File: rtl/bambu_slave_preloader_if.sv
// Bus bundle between the preloader (master view) and its surroundings: run control,
// input byte stream, Bambu slave RAM port and the HLS start/done pair.
interface bambu_slave_preloader_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 64,
   parameter int SIZE_W = 7
);
   logic                  go;
   logic [ADDR_W-1:0]     cfg_base_addr;
   logic [ADDR_W:0]       cfg_len;

   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;

   logic [1:0]            S_oe_ram;
   logic [1:0]            S_we_ram;
   logic [2*ADDR_W-1:0]   S_addr_ram;
   logic [2*DATA_W-1:0]   S_Wdata_ram;
   logic [2*SIZE_W-1:0]   S_data_ram_size;
   logic [1:0]            Sout_DataRdy;
   logic [2*DATA_W-1:0]   Sout_Rdata_ram;

   logic                  start_port;
   logic                  done_port;

   logic                  busy;
   logic                  result_valid;
   logic [31:0]           result_cycles;
   logic                  result_timeout;

   modport master (
      input  go, cfg_base_addr, cfg_len,
      input  in_valid, in_data,
      output in_ready,
      output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
      input  Sout_DataRdy, Sout_Rdata_ram,
      output start_port,
      input  done_port,
      output busy, result_valid, result_cycles, result_timeout
   );

   modport slave (
      output go, cfg_base_addr, cfg_len,
      output in_valid, in_data,
      input  in_ready,
      input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
      output Sout_DataRdy, Sout_Rdata_ram,
      input  start_port,
      output done_port,
      input  busy, result_valid, result_cycles, result_timeout
   );
endinterface

// File: rtl/bambu_slave_preloader.sv
// Loads a byte stream into a Bambu HLS top through slave RAM channel 0, then starts the
// kernel and reports its latency in clock cycles (or a timeout).
module bambu_slave_preloader #(
   parameter int          ADDR_W         = 7,
   parameter int          DATA_W         = 64,
   parameter int          SIZE_W         = 7,
   parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
   input  logic clock,
   input  logic reset,
   bambu_slave_preloader_if.master bus
);
   localparam int          LEN_W     = ADDR_W + 1;
   localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE, LOAD_BYTE, LOAD_WRITE, START, RUN, REPORT
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [7:0]        byte_q, byte_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [31:0]       res_cycles_q, res_cycles_d;
   logic              res_timeout_q, res_timeout_d;

   logic [LEN_W-1:0]  idx_inc;
   logic [ADDR_W-1:0] wr_addr;
   logic              unused_sink;

   // Address arithmetic is ADDR_W wide on purpose: base+index wraps around the memory.
   assign idx_inc     = idx_q + LEN_W'(1);
   assign wr_addr     = base_q + idx_q[ADDR_W-1:0];
   assign unused_sink = ^{bus.Sout_Rdata_ram, bus.Sout_DataRdy[1]};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         res_cycles_q  <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         res_cycles_q  <= res_cycles_d;
         res_timeout_q <= res_timeout_d;
      end
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      byte_q <= byte_d;
      cnt_q  <= cnt_d;
   end

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      len_d         = len_q;
      idx_d         = idx_q;
      byte_d        = byte_q;
      cnt_d         = cnt_q;
      res_cycles_d  = res_cycles_q;
      res_timeout_d = res_timeout_q;

      bus.in_ready        = 1'b0;
      bus.S_oe_ram        = 2'b00;
      bus.S_we_ram        = 2'b00;
      bus.S_addr_ram      = {(2*ADDR_W){1'b0}};
      bus.S_Wdata_ram     = {(2*DATA_W){1'b0}};
      bus.S_data_ram_size = {(2*SIZE_W){1'b0}};
      bus.start_port      = 1'b0;
      bus.busy            = (state_q != IDLE);
      bus.result_valid    = 1'b0;
      bus.result_cycles   = res_cycles_q;
      bus.result_timeout  = res_timeout_q;

      unique case (state_q)
         IDLE: begin
            if (bus.go) begin
               base_d  = bus.cfg_base_addr;
               len_d   = bus.cfg_len;
               idx_d   = '0;
               state_d = (bus.cfg_len == '0) ? START : LOAD_BYTE;
            end
         end
         LOAD_BYTE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               byte_d  = bus.in_data;
               state_d = LOAD_WRITE;
            end
         end
         LOAD_WRITE: begin
            // Everything below stays constant until the slave acknowledges.
            bus.S_we_ram[0]                  = 1'b1;
            bus.S_addr_ram[ADDR_W-1:0]       = wr_addr;
            bus.S_Wdata_ram[7:0]             = byte_q;
            bus.S_data_ram_size[SIZE_W-1:0]  = SIZE_W'(8);
            if (bus.Sout_DataRdy[0]) begin
               idx_d   = idx_inc;
               state_d = (idx_inc == len_q) ? START : LOAD_BYTE;
            end
         end
         START: begin
            bus.start_port = 1'b1;
            cnt_d          = 32'd2;
            if (bus.done_port) begin
               res_cycles_d  = 32'd1;
               res_timeout_d = 1'b0;
               state_d       = REPORT;
            end else if (TIMEOUT_C <= 32'd1) begin
               res_cycles_d  = TIMEOUT_C;
               res_timeout_d = 1'b1;
               state_d       = REPORT;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            // cnt_q is the cycle number of the current cycle, START being cycle 1.
            cnt_d = cnt_q + 32'd1;
            if (bus.done_port) begin
               res_cycles_d  = cnt_q;
               res_timeout_d = 1'b0;
               state_d       = REPORT;
            end else if (cnt_q == TIMEOUT_C) begin
               res_cycles_d  = TIMEOUT_C;
               res_timeout_d = 1'b1;
               state_d       = REPORT;
            end
         end
         REPORT: begin
            bus.result_valid = 1'b1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_bambu_slave_preloader.sv
// Randomized scoreboard bench for bambu_slave_preloader: expected writes, start pulses
// and results are queued at issue time and consumed by a negedge monitor.
module tb_bambu_slave_preloader;
   localparam int TMO = 50;

   logic clock;
   logic reset;

   bambu_slave_preloader_if #(.ADDR_W(7), .DATA_W(64), .SIZE_W(7)) bus ();

   bambu_slave_preloader #(
      .ADDR_W(7), .DATA_W(64), .SIZE_W(7), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int tests;
   int fails;
   int cyc;
   int go_cyc;
   bit mon_en;

   int          ack_delay;
   int unsigned valid_pct;
   int          done_delay;

   logic [14:0] exp_wr[$];
   int          exp_start[$];
   logic [32:0] exp_res[$];
   logic [7:0]  stream_q[$];
   logic [7:0]  pend[$];
   logic [32:0] last_res;

   int          rlen, rd, rack;
   int unsigned rvp;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_quiet(input string name);
      chk(name, 256'({bus.in_ready, bus.start_port, bus.busy, bus.result_valid,
                      bus.result_timeout, bus.result_cycles}), 256'(0));
      chk({name, "_ram"}, 256'({bus.S_oe_ram, bus.S_we_ram, bus.S_addr_ram,
                               bus.S_Wdata_ram, bus.S_data_ram_size}), 256'(0));
   endtask

   // Environment drivers (ack, stream, done) followed by the scoreboard monitor.
   initial begin
      int          wcnt;
      int          run_ctr;
      int          t;
      logic [14:0] ew;
      logic [32:0] er;
      wcnt    = 0;
      run_ctr = -1;
      forever begin
         @(negedge clock);
         if (bus.S_we_ram[0]) begin
            bus.Sout_DataRdy = {1'($urandom), (wcnt == ack_delay)};
            wcnt++;
         end else begin
            bus.Sout_DataRdy = 2'($urandom);
            wcnt = 0;
         end
         bus.Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};

         if (stream_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stream_q[0];
            if (bus.in_ready) void'(stream_q.pop_front());
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
         end

         if (bus.start_port) run_ctr = 0;
         else if (run_ctr >= 0) run_ctr++;
         bus.done_port = (run_ctr >= 0 && run_ctr == done_delay);

         if (mon_en && !reset) begin
            if (bus.S_we_ram[0]) begin
               chk("write_expected", 256'(exp_wr.size() != 0), 256'(1));
               if (exp_wr.size() != 0) begin
                  ew = exp_wr[0];
                  chk("write_bus",
                      256'({bus.S_oe_ram, bus.S_we_ram, bus.S_addr_ram, bus.S_data_ram_size, bus.S_Wdata_ram}),
                      256'({2'b00, 2'b01, 7'd0, ew[14:8], 7'd0, 7'd8, 120'd0, ew[7:0]}));
                  chk("ready_low_in_write", 256'(bus.in_ready), 256'(0));
                  if (bus.Sout_DataRdy[0]) void'(exp_wr.pop_front());
               end
            end else begin
               chk("ram_quiet", 256'({bus.S_oe_ram, bus.S_we_ram, bus.S_addr_ram,
                                      bus.S_Wdata_ram, bus.S_data_ram_size}), 256'(0));
            end

            if (bus.start_port) begin
               chk("start_expected", 256'(exp_start.size() != 0), 256'(1));
               if (exp_start.size() != 0) begin
                  t = exp_start.pop_front();
                  chk("writes_done_at_start", 256'(exp_wr.size()), 256'(0));
                  if (t >= 0) chk("start_cycle", 256'(cyc - go_cyc), 256'(t));
               end
            end

            if (bus.result_valid) begin
               chk("result_expected", 256'(exp_res.size() != 0), 256'(1));
               if (exp_res.size() != 0) begin
                  er = exp_res.pop_front();
                  chk("result", 256'({bus.result_timeout, bus.result_cycles}), 256'(er));
                  chk("busy_in_report", 256'(bus.busy), 256'(1));
               end
            end
         end
      end
   end

   task automatic fill_random(input int n);
      pend.delete();
      for (int i = 0; i < n; i++) pend.push_back(8'($urandom));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_wr.delete();
      exp_start.delete();
      exp_res.delete();
      stream_q.delete();
      done_delay = -2;
   endtask

   // Reference model: byte i lands at (base+i) mod 128; latency is done delay + 1, capped.
   task automatic issue_run(input logic [6:0] base, input int len, input int d,
                            input int ackd, input int unsigned vpct, input bit timing);
      int   ecyc;
      logic eto;
      for (int i = 0; i < len; i++) begin
         exp_wr.push_back({7'((int'(base) + i) % 128), pend[i]});
         stream_q.push_back(pend[i]);
      end
      if (d + 1 <= TMO) begin
         ecyc = d + 1;
         eto  = 1'b0;
      end else begin
         ecyc = TMO;
         eto  = 1'b1;
      end
      last_res = {eto, 32'(ecyc)};
      exp_res.push_back(last_res);
      exp_start.push_back(timing ? 2 * len + 1 : -1);
      ack_delay  = ackd;
      valid_pct  = vpct;
      done_delay = d;
      @(posedge clock);
      #1;
      bus.go            = 1'b1;
      bus.cfg_base_addr = base;
      bus.cfg_len       = 8'(len);
      go_cyc            = cyc;
      @(posedge clock);
      #1;
      bus.go            = 1'b0;
      bus.cfg_base_addr = 7'($urandom);
      bus.cfg_len       = 8'($urandom);
   endtask

   task automatic finish_run(input bit inject);
      int waitc;
      if (inject) begin
         repeat ($urandom_range(1, 6)) @(posedge clock);
         #1;
         if (bus.busy) begin
            bus.go            = 1'b1;
            bus.cfg_base_addr = 7'($urandom);
            bus.cfg_len       = 8'($urandom_range(1, 128));
            @(posedge clock);
            #1;
            bus.go = 1'b0;
         end
      end
      waitc = 0;
      while (exp_res.size() != 0 && waitc < 3000) begin
         @(posedge clock);
         #1;
         waitc++;
      end
      chk("run_completes", 256'(waitc < 3000), 256'(1));
      chk("idle_after_report", 256'(bus.busy), 256'(0));
      chk("result_held", 256'({bus.result_timeout, bus.result_cycles}), 256'(last_res));
      chk("all_writes_seen", 256'(exp_wr.size()), 256'(0));
      if (waitc >= 3000) do_reset();
   endtask

   task automatic reset_mid(input bit in_run, input string name);
      int waitc;
      fill_random(4);
      issue_run(7'h20, 4, 1000, 3, 100, 1'b0);
      waitc = 0;
      while (waitc < 500 && (in_run ? (exp_start.size() != 0) : !bus.S_we_ram[0])) begin
         @(posedge clock);
         #1;
         waitc++;
      end
      chk({name, "_reached"}, 256'(waitc < 500), 256'(1));
      if (in_run) begin
         repeat (3) @(posedge clock);
         #1;
      end
      do_reset();
      chk_quiet(name);
      repeat (60) @(posedge clock);
      #1;
      chk_quiet({name, "_stays_idle"});
   endtask

   initial begin
      tests               = 0;
      fails               = 0;
      mon_en              = 1'b0;
      reset               = 1'b1;
      go_cyc              = 0;
      ack_delay           = 0;
      valid_pct           = 100;
      done_delay          = -2;
      last_res            = '0;
      bus.go              = 1'b0;
      bus.cfg_base_addr   = '0;
      bus.cfg_len         = '0;
      bus.in_valid        = 1'b0;
      bus.in_data         = '0;
      bus.Sout_DataRdy    = '0;
      bus.Sout_Rdata_ram  = '0;
      bus.done_port       = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      chk_quiet("reset_state");

      pend = {8'hA1, 8'hB2, 8'hC3};
      issue_run(7'h10, 3, 10, 0, 100, 1'b1);
      finish_run(1'b0);

      fill_random(6);
      issue_run(7'h40, 6, 20, 3, 40, 1'b0);
      finish_run(1'b0);

      fill_random(4);
      issue_run(7'h7E, 4, 5, 0, 100, 1'b1);
      finish_run(1'b0);

      pend.delete();
      issue_run(7'h33, 0, 0, 0, 100, 1'b1);
      finish_run(1'b0);

      fill_random(2);
      issue_run(7'h05, 2, 100000, 1, 100, 1'b0);
      finish_run(1'b1);

      fill_random(1);
      issue_run(7'h06, 1, TMO - 1, 0, 100, 1'b1);
      finish_run(1'b0);

      reset_mid(1'b0, "rst_in_write");
      reset_mid(1'b1, "rst_in_run");

      pend = {8'hA1, 8'hB2, 8'hC3};
      issue_run(7'h10, 3, 10, 0, 100, 1'b1);
      finish_run(1'b1);

      fill_random(128);
      issue_run(7'($urandom), 128, 3, 0, 100, 1'b1);
      finish_run(1'b0);

      for (int n = 0; n < 25; n++) begin
         rlen = int'($urandom_range(0, 12));
         rd   = ($urandom_range(0, 3) == 0) ? 100000 : int'($urandom_range(0, 60));
         rack = int'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0:       rvp = 100;
            1:       rvp = 60;
            default: rvp = 30;
         endcase
         fill_random(rlen);
         issue_run(7'($urandom), rlen, rd, rack, rvp, (rack == 0 && rvp == 100));
         finish_run(1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
